// File: rtl/stm1_framer_pkg.sv
// Shared constants, types and the overhead-byte lookup for the STM-1 framer.
package stm1_framer_pkg;

    localparam int STM1_COLS = 270;
    localparam int STM1_ROWS = 9;
    localparam int SOH_COLS  = 9;

    localparam logic [9:0] AU4_PTR   = 10'd522;
    localparam logic [7:0] A1_BYTE   = 8'hF6;
    localparam logic [7:0] A2_BYTE   = 8'h28;
    // H1 carries NDF=0110, SS=10 and the top two pointer bits; H2 the low byte.
    localparam logic [7:0] H1_BYTE   = {4'b0110, 2'b10, AU4_PTR[9:8]};
    localparam logic [7:0] H2_BYTE   = AU4_PTR[7:0];
    localparam logic [7:0] Y_BYTE    = 8'h9B;
    localparam logic [7:0] ALL1_BYTE = 8'hFF;

    typedef struct packed {
        logic       sof;
        logic [7:0] data;
    } fifo_entry_t;

    typedef enum logic {
        IDLE,
        FRAME
    } framer_state_t;

    function automatic logic [7:0] soh_byte(input logic [3:0] row, input logic [8:0] col,
                                            input logic [7:0] j0);
        logic [7:0] b;
        b = 8'h00;
        if (row == 4'd1) begin
            if (col <= 9'd3)      b = A1_BYTE;
            else if (col <= 9'd6) b = A2_BYTE;
            else if (col == 9'd7) b = j0;
        end else if (row == 4'd4) begin
            case (col)
                9'd1:       b = H1_BYTE;
                9'd2, 9'd3: b = Y_BYTE;
                9'd4:       b = H2_BYTE;
                9'd5, 9'd6: b = ALL1_BYTE;
                default:    b = 8'h00;
            endcase
        end
        return b;
    endfunction

endpackage

// File: rtl/stm1_framer_sync_byte_fifo.sv
// Single-clock first-word-fall-through FIFO of {sof, data} entries.
module sync_byte_fifo
    import stm1_framer_pkg::*;
#(
    parameter int DEPTH = 512
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  fifo_entry_t push_data,
    input  logic        pop,
    output fifo_entry_t head,
    output logic        full,
    output logic        empty
);
    localparam int AW = $clog2(DEPTH);

    fifo_entry_t    mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]    count_q, count_d;
    logic           do_push, do_pop;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    // Storage is not reset; flushing is done by clearing the pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/stm1_framer.sv
// Maps a byte-serial VC-4 into an STM-1 frame with fixed AU-4 pointer 522,
// inserting section/AU overhead and flagging misaligned J1 bytes.
module stm1_framer
    import stm1_framer_pkg::*;
#(
    parameter int         FIFO_DEPTH = 512,
    parameter logic [7:0] J0_BYTE    = 8'h01
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] vc4_data,
    input  logic       vc4_sof,
    input  logic       vc4_valid,
    output logic       vc4_ready,
    output logic [7:0] stm1_data,
    output logic       stm1_sof,
    output logic       stm1_valid,
    input  logic       stm1_ready,
    output logic [3:0] stm1_row,
    output logic [8:0] stm1_col,
    output logic       sof_err
);
    framer_state_t state_q, state_d;
    logic [3:0]    row_q, row_d, orow_q, orow_d;
    logic [8:0]    col_q, col_d, ocol_q, ocol_d;
    logic [7:0]    data_q, data_d;
    logic          sof_q, sof_d, valid_q, valid_d, err_q, err_d, ready_q, ready_d;
    fifo_entry_t   in_entry, head;
    logic          full, empty, push, pop;
    logic          load, in_soh, at_j1, gen_valid;

    assign in_entry   = {vc4_sof, vc4_data};
    assign vc4_ready  = ready_q && !full;
    assign push       = vc4_valid && vc4_ready;
    assign stm1_data  = data_q;
    assign stm1_sof   = sof_q;
    assign stm1_valid = valid_q;
    assign stm1_row   = orow_q;
    assign stm1_col   = ocol_q;
    assign sof_err    = err_q;

    sync_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (in_entry),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

    // row_q/col_q track the next position to generate; the o*_q registers
    // hold the byte currently presented downstream.
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        data_d    = data_q;
        sof_d     = sof_q;
        valid_d   = valid_q;
        orow_d    = orow_q;
        ocol_d    = ocol_q;
        err_d     = 1'b0;
        ready_d   = 1'b1;
        pop       = 1'b0;
        load      = !valid_q || stm1_ready;
        in_soh    = (col_q <= 9'(SOH_COLS));
        at_j1     = (row_q == 4'd1) && (col_q == 9'(SOH_COLS + 1));
        gen_valid = in_soh || !empty;
        if (load) valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (!empty) begin
                    if (head.sof) begin
                        state_d = FRAME;
                        row_d   = 4'd1;
                        col_d   = 9'd1;
                    end else begin
                        pop = 1'b1;
                    end
                end
            end
            FRAME: begin
                if (load && gen_valid) begin
                    valid_d = 1'b1;
                    sof_d   = (row_q == 4'd1) && (col_q == 9'd1);
                    orow_d  = row_q;
                    ocol_d  = col_q;
                    if (in_soh) begin
                        data_d = soh_byte(row_q, col_q, J0_BYTE);
                    end else begin
                        data_d = head.data;
                        pop    = 1'b1;
                        err_d  = (head.sof != at_j1);
                    end
                    if (col_q == 9'(STM1_COLS)) begin
                        col_d = 9'd1;
                        row_d = (row_q == 4'(STM1_ROWS)) ? 4'd1 : row_q + 4'd1;
                    end else begin
                        col_d = col_q + 9'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            row_q   <= 4'd1;
            col_q   <= 9'd1;
            data_q  <= 8'h00;
            sof_q   <= 1'b0;
            valid_q <= 1'b0;
            orow_q  <= 4'd1;
            ocol_q  <= 9'd1;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            data_q  <= data_d;
            sof_q   <= sof_d;
            valid_q <= valid_d;
            orow_q  <= orow_d;
            ocol_q  <= ocol_d;
            err_q   <= err_d;
            ready_q <= ready_d;
        end
    end

endmodule

// File: tb/tb_stm1_framer.sv
// Directed bench for stm1_framer: clean, backpressured, underflowing,
// garbage-prefixed, misaligned and reset-interrupted frames.
module tb_stm1_framer;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] vc4_data;
    logic       vc4_sof, vc4_valid, vc4_ready;
    logic [7:0] stm1_data;
    logic       stm1_sof, stm1_valid, stm1_ready;
    logic [3:0] stm1_row;
    logic [8:0] stm1_col;
    logic       sof_err;

    int checks = 0;
    int failures = 0;
    int cyc_now = 0;

    logic [8:0] stim_q[$];
    int         gap_q[$];
    logic [7:0] got_data[$];
    logic [3:0] got_row[$];
    logic [8:0] got_col[$];
    logic       got_sof[$];
    int         err_col[$], err_row[$];
    int         stall_err, hold_err, idle_cnt, stall_row, first_valid_cyc, sof_acc_cyc;
    bit         feed_stop, feed_timeout, col_timeout;

    stm1_framer #(.FIFO_DEPTH(512), .J0_BYTE(8'h01)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .vc4_data   (vc4_data),
        .vc4_sof    (vc4_sof),
        .vc4_valid  (vc4_valid),
        .vc4_ready  (vc4_ready),
        .stm1_data  (stm1_data),
        .stm1_sof   (stm1_sof),
        .stm1_valid (stm1_valid),
        .stm1_ready (stm1_ready),
        .stm1_row   (stm1_row),
        .stm1_col   (stm1_col),
        .sof_err    (sof_err)
    );

    always #5 clk = ~clk;
    always @(negedge clk) cyc_now <= cyc_now + 1;

    function automatic logic [7:0] pay(input int p, input int seed);
        int v;
        v = p * 7 + seed * 31 + p / 256;
        return v[7:0];
    endfunction

    function automatic logic [7:0] exp_oh(input int row, input int col);
        if (row == 1) begin
            if (col <= 3) return 8'hF6;
            if (col <= 6) return 8'h28;
            if (col == 7) return 8'h01;
        end
        if (row == 4) begin
            case (col)
                1:       return 8'h6A;
                2, 3:    return 8'h9B;
                4:       return 8'h0A;
                5, 6:    return 8'hFF;
                default: return 8'h00;
            endcase
        end
        return 8'h00;
    endfunction

    // Number of captured bytes that differ from the expected frame stream.
    function automatic int frame_errors(input int n, input int s0, input int s1);
        int bad = 0;
        for (int k = 0; k < n; k++) begin
            int r   = k % 2430;
            int row = r / 270 + 1;
            int col = r % 270 + 1;
            logic [7:0] e;
            e = (col <= 9) ? exp_oh(row, col) : pay((row - 1) * 261 + col - 10, (k >= 2430) ? s1 : s0);
            if (k >= got_data.size()) bad++;
            else if (got_data[k] !== e || got_row[k] !== 4'(row) || got_col[k] !== 9'(col)
                     || got_sof[k] !== (r == 0)) bad++;
        end
        return bad;
    endfunction

    task automatic clear_capture();
        stim_q.delete(); gap_q.delete();
        got_data.delete(); got_row.delete(); got_col.delete(); got_sof.delete();
        err_col.delete(); err_row.delete();
        stall_err = 0; hold_err = 0; idle_cnt = 0;
        stall_row = -1; first_valid_cyc = -1; sof_acc_cyc = -1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; vc4_valid = 1'b0; vc4_sof = 1'b0; vc4_data = 8'h00; stm1_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic add_frame(input int seed, input int sof_idx, input int gap_idx, input int gap_len);
        for (int p = 0; p < 2349; p++) begin
            stim_q.push_back({(p == sof_idx), pay(p, seed)});
            gap_q.push_back((p == gap_idx) ? gap_len : 0);
        end
    endtask

    task automatic feed();
        int cyc = 0;
        bit accepted;
        for (int i = 0; i < stim_q.size() && !feed_stop; i++) begin
            for (int g = 0; g < gap_q[i]; g++) begin
                @(negedge clk);
                vc4_valid = 1'b0;
            end
            accepted = 1'b0;
            while (!accepted && !feed_stop && cyc < 20000) begin
                @(negedge clk);
                vc4_valid = 1'b1; vc4_sof = stim_q[i][8]; vc4_data = stim_q[i][7:0];
                #1;
                cyc++;
                if (vc4_ready) begin
                    accepted = 1'b1;
                    if (vc4_sof && sof_acc_cyc < 0) sof_acc_cyc = cyc_now;
                end
            end
            if (!accepted && !feed_stop) begin
                feed_timeout = 1'b1;
                break;
            end
        end
        @(negedge clk);
        vc4_valid = 1'b0; vc4_sof = 1'b0;
    endtask

    task automatic collect(input int nbytes, input bit rand_ready);
        int cyc = 0;
        bit have_prev = 1'b0, pstall = 1'b0;
        logic [7:0] pd; logic [3:0] pr; logic [8:0] pc; logic ps;
        while (got_data.size() < nbytes && cyc < 20000) begin
            @(negedge clk);
            stm1_ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
            #1;
            cyc++;
            if (sof_err) begin
                err_col.push_back(int'(stm1_col));
                err_row.push_back(int'(stm1_row));
            end
            if (pstall && {stm1_valid, stm1_sof, stm1_data, stm1_row, stm1_col} !== {1'b1, ps, pd, pr, pc})
                stall_err++;
            if (have_prev && !stm1_valid && {stm1_row, stm1_col} !== {pr, pc}) hold_err++;
            if (stm1_valid && first_valid_cyc < 0) first_valid_cyc = cyc_now;
            if (!stm1_valid && got_data.size() > 0) begin
                idle_cnt++;
                if (stall_row < 0) stall_row = int'(stm1_row);
            end
            if (stm1_valid && stm1_ready) begin
                got_data.push_back(stm1_data); got_row.push_back(stm1_row);
                got_col.push_back(stm1_col);   got_sof.push_back(stm1_sof);
            end
            pstall = stm1_valid && !stm1_ready;
            pd = stm1_data; pr = stm1_row; pc = stm1_col; ps = stm1_sof;
            have_prev = 1'b1;
        end
        col_timeout = (got_data.size() < nbytes);
        feed_stop = 1'b1;
        @(negedge clk);
        stm1_ready = 1'b1;
    endtask

    task automatic run(input int nbytes, input bit rand_ready);
        feed_stop = 1'b0; feed_timeout = 1'b0; col_timeout = 1'b0;
        fork
            feed();
            collect(nbytes, rand_ready);
        join
        checks++;
        if (col_timeout || feed_timeout) begin
            failures++;
            $display("[TB] FAIL run_timeout got=%0d bytes required=%0d feed_timeout=%0b", got_data.size(), nbytes, feed_timeout);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1; vc4_valid = 1'b0; vc4_sof = 1'b0; vc4_data = 8'h00; stm1_ready = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({stm1_valid, stm1_sof, sof_err, vc4_ready} !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL reset_flags got=%b required=0000", {stm1_valid, stm1_sof, sof_err, vc4_ready});
        end
        checks++;
        if (stm1_data !== 8'h00) begin failures++; $display("[TB] FAIL reset_data got=%h required=00", stm1_data); end
        checks++;
        if (stm1_row !== 4'd1 || stm1_col !== 9'd1) begin
            failures++; $display("[TB] FAIL reset_pos got=%0d/%0d required=1/1", stm1_row, stm1_col);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (vc4_ready !== 1'b1 || stm1_valid !== 1'b0) begin
            failures++; $display("[TB] FAIL post_reset got ready=%b valid=%b required ready=1 valid=0", vc4_ready, stm1_valid);
        end
    endtask

    task automatic test_clean_frame();
        logic [7:0] row4 [9] = '{8'h6A, 8'h9B, 8'h9B, 8'h0A, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00};
        int bad;
        do_reset(); clear_capture();
        add_frame(1, 0, -1, 0);
        run(2430, 1'b0);
        for (int i = 0; i < 7; i++) begin
            logic [7:0] e;
            e = (i < 3) ? 8'hF6 : (i < 6) ? 8'h28 : 8'h01;
            checks++;
            if (got_data[i] !== e) begin failures++; $display("[TB] FAIL clean_row1[%0d] got=%h required=%h", i, got_data[i], e); end
        end
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (got_data[810 + i] !== row4[i]) begin
                failures++; $display("[TB] FAIL clean_row4[%0d] got=%h required=%h", i + 1, got_data[810 + i], row4[i]);
            end
        end
        checks++;
        if (got_data[9] !== 8'h1F) begin failures++; $display("[TB] FAIL clean_j1 got=%h required=1f", got_data[9]); end
        checks++;
        if (got_sof[0] !== 1'b1) begin failures++; $display("[TB] FAIL clean_sof got=%b required=1", got_sof[0]); end
        checks++;
        if (err_col.size() != 0) begin failures++; $display("[TB] FAIL clean_sof_err got=%0d pulses required=0", err_col.size()); end
        checks++;
        if (first_valid_cyc - sof_acc_cyc != 3) begin
            failures++; $display("[TB] FAIL clean_latency got=%0d required=3", first_valid_cyc - sof_acc_cyc);
        end
        bad = frame_errors(2430, 1, 1);
        checks++;
        if (bad != 0) begin failures++; $display("[TB] FAIL clean_frame got=%0d bad bytes required=0", bad); end
    endtask

    task automatic test_backpressure();
        int bad;
        do_reset(); clear_capture();
        add_frame(2, 0, -1, 0);
        run(2430, 1'b1);
        bad = frame_errors(2430, 2, 2);
        checks++;
        if (bad != 0) begin failures++; $display("[TB] FAIL bp_frame got=%0d bad bytes required=0", bad); end
        checks++;
        if (stall_err != 0) begin failures++; $display("[TB] FAIL bp_stable got=%0d unstable cycles required=0", stall_err); end
        checks++;
        if (err_col.size() != 0) begin failures++; $display("[TB] FAIL bp_sof_err got=%0d pulses required=0", err_col.size()); end
    endtask

    task automatic test_underflow();
        int bad;
        do_reset(); clear_capture();
        add_frame(3, 0, 1144, 80);
        run(2430, 1'b0);
        bad = frame_errors(2430, 3, 3);
        checks++;
        if (bad != 0) begin failures++; $display("[TB] FAIL uf_frame got=%0d bad bytes required=0", bad); end
        checks++;
        if (hold_err != 0) begin failures++; $display("[TB] FAIL uf_hold got=%0d moved cycles required=0", hold_err); end
        checks++;
        if (idle_cnt < 20 || idle_cnt > 80) begin failures++; $display("[TB] FAIL uf_idle got=%0d required 20..80", idle_cnt); end
        checks++;
        if (stall_row != 5) begin failures++; $display("[TB] FAIL uf_row got=%0d required=5", stall_row); end
    endtask

    task automatic test_presof_garbage();
        int bad;
        do_reset(); clear_capture();
        for (int i = 0; i < 5; i++) begin
            stim_q.push_back({1'b0, 8'(8'hA0 + i)});
            gap_q.push_back(0);
        end
        add_frame(4, 0, -1, 0);
        run(2430, 1'b0);
        checks++;
        if (got_data[0] !== 8'hF6 || got_sof[0] !== 1'b1) begin
            failures++; $display("[TB] FAIL garbage_first got=%h/%b required=f6/1", got_data[0], got_sof[0]);
        end
        checks++;
        if (got_data[9] !== 8'h7C) begin failures++; $display("[TB] FAIL garbage_j1 got=%h required=7c", got_data[9]); end
        bad = frame_errors(2430, 4, 4);
        checks++;
        if (bad != 0 || err_col.size() != 0) begin
            failures++; $display("[TB] FAIL garbage_frame got=%0d bad bytes %0d pulses required=0/0", bad, err_col.size());
        end
    endtask

    task automatic test_misalign();
        int bad;
        do_reset(); clear_capture();
        add_frame(5, 0, -1, 0);
        add_frame(6, 99, -1, 0);
        run(4860, 1'b0);
        checks++;
        if (err_col.size() != 2) begin failures++; $display("[TB] FAIL mis_count got=%0d pulses required=2", err_col.size()); end
        checks++;
        if (err_row[0] !== 1 || err_col[0] !== 10) begin
            failures++; $display("[TB] FAIL mis_first got=%0d/%0d required=1/10", err_row[0], err_col[0]);
        end
        checks++;
        if (err_row[1] !== 1 || err_col[1] !== 109) begin
            failures++; $display("[TB] FAIL mis_stray got=%0d/%0d required=1/109", err_row[1], err_col[1]);
        end
        bad = frame_errors(4860, 5, 6);
        checks++;
        if (bad != 0) begin failures++; $display("[TB] FAIL mis_frames got=%0d bad bytes required=0", bad); end
    endtask

    task automatic test_reset_midframe();
        int bad;
        do_reset(); clear_capture();
        add_frame(7, 0, -1, 0);
        run(1370, 1'b0);
        checks++;
        if (got_row[1369] !== 4'd6) begin failures++; $display("[TB] FAIL mid_row got=%0d required=6", got_row[1369]); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({stm1_valid, stm1_sof, sof_err, vc4_ready} !== 4'b0000 || stm1_data !== 8'h00) begin
            failures++; $display("[TB] FAIL mid_reset_out got=%b data=%h required=0000 data=00",
                                 {stm1_valid, stm1_sof, sof_err, vc4_ready}, stm1_data);
        end
        checks++;
        if (stm1_row !== 4'd1 || stm1_col !== 9'd1) begin
            failures++; $display("[TB] FAIL mid_reset_pos got=%0d/%0d required=1/1", stm1_row, stm1_col);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clear_capture();
        add_frame(8, 0, -1, 0);
        run(2430, 1'b0);
        checks++;
        if (got_sof[0] !== 1'b1 || got_data[0] !== 8'hF6) begin
            failures++; $display("[TB] FAIL mid_restart got=%b/%h required=1/f6", got_sof[0], got_data[0]);
        end
        bad = frame_errors(2430, 8, 8);
        checks++;
        if (bad != 0) begin failures++; $display("[TB] FAIL mid_frame got=%0d bad bytes required=0", bad); end
    endtask

    initial begin
        clear_capture();
        test_reset();
        test_clean_frame();
        test_backpressure();
        test_underflow();
        test_presof_garbage();
        test_misalign();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
